handshake_sender: RTL and testbench

- Sending end of a four-phase req/ack handshake that carries a data word across a clock-domain intersection.
- Accepts a word from local logic via valid/ready and drives req with the data held stable.
- Synchronises the asynchronous ack returned by the receiving domain and completes the four phases.
- Reports completion, timeout, and a running transfer count; sits opposite the receiving block of the intersection.

---
 rtl/handshake_sender.sv | 146 ++++++++++++++
 tb/tb_handshake_sender.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_sender.sv
// Sending end of a four-phase req/ack handshake: takes a word over valid/ready,
// holds it on tx_data while req is high and completes req/ack through a synchronised ack.
module handshake_sender #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send_valid,
    input  logic [DATA_WIDTH-1:0] send_data,
    output logic                  send_ready,
    output logic                  req,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  ack_async,
    output logic                  done,
    output logic                  timeout,
    output logic [15:0]           xfer_count
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACK_HI,
        S_WAIT_ACK_LO,
        S_ABORT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SYNC_STAGES-1:0]  r_ack_sync;
    logic                    w_ack_sync;
    logic                    r_req;
    logic                    w_req_next;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_done;
    logic                    w_done_next;
    logic                    w_timeout;
    logic                    w_accept;
    logic                    w_send_ready;
    logic                    w_expired;
    logic [15:0]             r_xfer_count;
    logic [TW-1:0]           r_tcnt;

    // ack_async crosses into clk here; nothing else looks at the raw input
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) begin
                r_ack_sync[gi] <= 1'b0;
            end else if (gi == 0) begin
                r_ack_sync[gi] <= ack_async;
            end else begin
                r_ack_sync[gi] <= r_ack_sync[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    assign w_ack_sync = r_ack_sync[SYNC_STAGES-1];
    assign w_expired  = (TIMEOUT_CYCLES > 0) && (r_tcnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_done_next  = 1'b0;
        w_timeout    = 1'b0;
        w_accept     = 1'b0;
        w_send_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                // a lingering ack from a previous exchange must drain before a new accept
                w_send_ready = ~w_ack_sync;
                if (send_valid && !w_ack_sync) begin
                    w_accept     = 1'b1;
                    w_req_next   = 1'b1;
                    w_state_next = S_WAIT_ACK_HI;
                end
            end
            S_WAIT_ACK_HI: begin
                if (w_ack_sync) begin
                    w_req_next   = 1'b0;
                    w_state_next = S_WAIT_ACK_LO;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_req_next   = 1'b0;
                    w_state_next = S_ABORT;
                end
            end
            S_WAIT_ACK_LO: begin
                if (!w_ack_sync) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_req_next   = 1'b0;
                    w_state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                w_req_next = 1'b0;
                if (!w_ack_sync) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_req_next   = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_tx_data    <= '0;
            r_done       <= 1'b0;
            r_xfer_count <= '0;
            r_tcnt       <= '0;
        end else begin
            r_state <= w_state_next;
            r_req   <= w_req_next;
            r_done  <= w_done_next;
            if (w_accept) begin
                r_tx_data <= send_data;
            end
            if (w_done_next) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
            // wait-state age: zero on the first cycle of each wait state
            if (w_state_next != r_state) begin
                r_tcnt <= '0;
            end else if (r_state == S_WAIT_ACK_HI || r_state == S_WAIT_ACK_LO) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    assign send_ready = w_send_ready;
    assign req        = r_req;
    assign tx_data    = r_tx_data;
    assign done       = r_done;
    assign timeout    = w_timeout;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_handshake_sender.sv
// Bench for handshake_sender: a delayed-mirror ack responder plus transaction-level
// expectations (latency formulas, word queue, transfer count) checked every transfer.
module tb_handshake_sender;

    localparam int DW = 8;
    localparam int S  = 2;
    localparam int T  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          send_valid = 1'b0;
    logic [DW-1:0] send_data = '0;
    logic          send_ready;
    logic          req;
    logic [DW-1:0] tx_data;
    logic          ack_async;
    logic          done;
    logic          timeout;
    logic [15:0]   xfer_count;

    // responder: 0 = mirror req after ack_dly clocks, 1 = stuck low, 2 = stuck high
    int            ack_mode = 1;
    int            ack_dly  = 0;
    logic [7:0]    req_line = '0;

    int            n_vec = 0;
    int            n_err = 0;
    logic [15:0]   model_count = '0;

    handshake_sender #(
        .DATA_WIDTH    (DW),
        .SYNC_STAGES   (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .send_valid(send_valid),
        .send_data (send_data),
        .send_ready(send_ready),
        .req       (req),
        .tx_data   (tx_data),
        .ack_async (ack_async),
        .done      (done),
        .timeout   (timeout),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) req_line <= {req_line[6:0], req};

    always_comb begin
        ack_async = 1'b0;
        case (ack_mode)
            0:       ack_async = (ack_dly == 0) ? req : req_line[ack_dly-1];
            2:       ack_async = 1'b1;
            default: ack_async = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // one transfer with the responder mirroring after d clocks; entered and left at a negedge
    task automatic run_xfer(input logic [DW-1:0] word, input int d, input string tag);
        int k;
        int t_fall;
        int t_done;
        int bad;
        int n_to;
        ack_mode = 0;
        ack_dly  = d;
        check({tag, "_ready_before"}, send_ready, 1);
        send_valid = 1'b1;
        send_data  = word;
        @(negedge clk);
        send_valid = 1'b0;
        k = 1; t_fall = 0; t_done = 0; bad = 0; n_to = 0;
        while (k <= 60 && t_done == 0) begin
            if (t_fall == 0) begin
                if (req) begin
                    if (tx_data !== word) bad++;
                end else begin
                    t_fall = k;
                end
            end
            if (timeout) n_to++;
            if (done) t_done = k;
            if (t_done == 0) begin
                @(negedge clk);
                k++;
                send_data = DW'($urandom);
            end
        end
        model_count = model_count + 16'd1;
        check({tag, "_req_high_cycles"}, t_fall - 1, 1 + d + S);
        check({tag, "_done_latency"}, t_done, 3 + 2 * d + 2 * S);
        check({tag, "_tx_data_stable"}, bad, 0);
        check({tag, "_no_timeout"}, n_to, 0);
        check({tag, "_xfer_count"}, xfer_count, model_count);
        check({tag, "_ready_at_done"}, send_ready, 1);
        @(negedge clk);
        check({tag, "_done_single"}, done, 0);
        check({tag, "_tx_data_hold"}, tx_data, word);
    endtask

    initial begin
        int k;
        int t_to;
        int t_fall;
        int t_idle;
        int n_done;
        int n_to;
        int bad;
        logic [DW-1:0] words [3];

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req", req, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_ready", send_ready, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_xfer_count", xfer_count, 0);
        repeat (10) @(negedge clk);

        // basic transfer
        run_xfer(8'hA5, 3, "basic");
        repeat (6) @(negedge clk);

        // random words and responder delays
        for (int i = 0; i < 12; i++) begin
            run_xfer(DW'($urandom), int'($urandom_range(0, 4)), $sformatf("rand%0d", i));
            repeat (6 + int'($urandom_range(0, 3))) @(negedge clk);
        end

        // back-to-back with send_valid held
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
        ack_mode   = 0;
        ack_dly    = 1;
        send_valid = 1'b1;
        send_data  = words[0];
        check("b2b_ready_first", send_ready, 1);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            check($sformatf("b2b%0d_req", w), req, 1);
            check($sformatf("b2b%0d_tx_data", w), tx_data, words[w]);
            if (w < 2) send_data = words[w+1];
            else       send_valid = 1'b0;
            k = 0;
            while (k < 40 && !done) begin
                @(negedge clk);
                k++;
            end
            model_count = model_count + 16'd1;
            check($sformatf("b2b%0d_done_seen", w), done, 1);
            check($sformatf("b2b%0d_xfer_count", w), xfer_count, model_count);
            if (w < 2) check($sformatf("b2b%0d_accept_on_done", w), send_ready, 1);
        end
        repeat (8) @(negedge clk);

        // timeout with ack stuck low
        ack_mode   = 1;
        check("to_ready_before", send_ready, 1);
        send_valid = 1'b1;
        send_data  = 8'h5A;
        @(negedge clk);
        send_valid = 1'b0;
        k = 1; t_to = 0; t_fall = 0; t_idle = 0; n_done = 0; n_to = 0;
        while (k <= 40 && t_idle == 0) begin
            if (timeout) begin
                n_to++;
                if (t_to == 0) t_to = k;
            end
            if (!req && t_fall == 0) t_fall = k;
            if (done) n_done++;
            if (send_ready && t_to != 0) t_idle = k;
            if (t_idle == 0) begin
                @(negedge clk);
                k++;
            end
        end
        check("to_pulse_cycle", t_to, T + 1);
        check("to_pulse_count", n_to, 1);
        check("to_req_fall", t_fall, T + 2);
        check("to_back_idle", t_idle, T + 3);
        check("to_no_done", n_done, 0);
        check("to_xfer_count", xfer_count, model_count);
        check("to_tx_data_hold", tx_data, 8'h5A);
        repeat (4) @(negedge clk);

        // stale ack present across reset release
        ack_mode = 2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_count = '0;
        repeat (S + 1) @(negedge clk);
        send_valid = 1'b1;
        send_data  = 8'h3C;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (send_ready !== 1'b0 || req !== 1'b0) bad++;
        end
        check("stale_blocked", bad, 0);
        send_valid = 1'b0;
        ack_mode   = 1;
        k = 0;
        while (k <= S + 3 && !send_ready) begin
            @(negedge clk);
            k++;
        end
        check("stale_ready_within", (k >= 1 && k <= S + 1) ? 1 : 0, 1);
        check("stale_xfer_count", xfer_count, model_count);
        repeat (2) @(negedge clk);

        // reset while waiting for ack
        send_valid = 1'b1;
        send_data  = 8'h77;
        @(negedge clk);
        send_valid = 1'b0;
        check("midrst_req_before", req, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_count = '0;
        check("midrst_req", req, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_xfer_count", xfer_count, model_count);
        check("midrst_ready", send_ready, 1);
        check("midrst_done", done, 0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("midrst_no_done_later", n_done, 0);
        repeat (6) @(negedge clk);

        // counter wrap
        force dut.r_xfer_count = 16'hFFFF;
        #1;
        release dut.r_xfer_count;
        model_count = 16'hFFFF;
        @(negedge clk);
        check("wrap_preset", xfer_count, model_count);
        run_xfer(8'hC3, 1, "wrap");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
